// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, FSM state type and opcode classification for alu_seq.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_BNE  = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    // IDLE accepts requests; RUN means the iterative unit owns the ALU.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // True for opcodes that go through the iterative multiply/divide unit.
    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add, LSB of b first) and restoring
// divide/remainder (MSB first), one bit per clock, WIDTH iterations.
// The three working registers are shared between the two algorithms:
//   r_acc : product accumulator       | partial remainder
//   r_opa : shifted multiplicand      | divisor
//   r_opb : multiplier (shifts right) | dividend shifting out / quotient in
module alu_iter_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam int CW = $clog2(WIDTH);

    logic             r_active;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;

    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_opa_nxt;
    logic [WIDTH-1:0] w_opb_nxt;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_diff;
    logic             w_rem_ge;

    // Restoring-division step: bring in the next dividend bit and try to subtract.
    assign w_rem_sh   = {r_acc, r_opb[WIDTH-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_opa};
    assign w_rem_ge   = ~w_rem_diff[WIDTH];

    // One iteration of whichever algorithm is running.
    always_comb begin
        w_acc_nxt = r_acc;
        w_opa_nxt = r_opa;
        w_opb_nxt = r_opb;
        if (r_op == OP_MUL) begin
            w_acc_nxt = r_opb[0] ? (r_acc + r_opa) : r_acc;
            w_opa_nxt = {r_opa[WIDTH-2:0], 1'b0};
            w_opb_nxt = {1'b0, r_opb[WIDTH-1:1]};
        end else begin
            w_acc_nxt = w_rem_ge ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            w_opb_nxt = {r_opb[WIDTH-2:0], w_rem_ge};
        end
    end

    // done marks the final iteration; res is that iteration's outcome so the
    // top level can register it on the same edge.
    assign done = r_active && (r_cnt == CW'(WIDTH - 1));
    assign res  = (r_op == OP_DIVU) ? w_opb_nxt : w_acc_nxt;

    // Load operands on start, iterate while active, abandon on kill.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_op     <= OP_AND;
            r_acc    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
        end else if (kill) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_op     <= op;
            r_acc    <= '0;
            r_opa    <= (op == OP_MUL) ? a : b;
            r_opb    <= (op == OP_MUL) ? b : a;
        end else if (r_active) begin
            r_cnt <= r_cnt + 1'b1;
            r_acc <= w_acc_nxt;
            r_opa <= w_opa_nxt;
            r_opb <= w_opb_nxt;
            if (done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered EX-stage ALU: single-cycle ops complete in one cycle, MUL/DIVU/REMU
// run through the iterative unit in WIDTH cycles.
// Handshake: a request is taken on a rising edge where in_valid && in_ready &&
// !flush. Results appear as a one-cycle out_valid pulse with no backpressure;
// result/zero hold their last value otherwise. busy (== RUN) stalls the pipe.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             out_valid,
    output logic             busy,
    output state_t           o_dbg_state
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_multi;
    logic             w_start;
    logic             w_sc_fire;
    logic             w_mc_fire;
    logic             w_done;
    logic [WIDTH-1:0] w_mc_res;
    logic [WIDTH-1:0] w_sub;
    logic             w_ltu;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_zero;

    assign w_sub = a - b;
    assign w_ltu = (a < b);

    // Single-cycle datapath: result and branch flag for the current opcode.
    always_comb begin
        w_sc_res  = '0;
        w_sc_zero = 1'b0;
        case (alu_op)
            OP_AND:  w_sc_res = a & b;
            OP_OR:   w_sc_res = a | b;
            OP_ADD:  w_sc_res = a + b;
            OP_BEQ: begin
                w_sc_res  = w_sub;
                w_sc_zero = (a == b);
            end
            OP_BNE: begin
                w_sc_res  = w_sub;
                w_sc_zero = (a != b);
            end
            OP_SLL:  w_sc_res = a << b[SHW-1:0];
            OP_SLTU: begin
                w_sc_res  = {{(WIDTH-1){1'b0}}, w_ltu};
                w_sc_zero = w_ltu;
            end
            default: w_sc_res = ~(a | b);
        endcase
    end

    assign w_multi   = is_multicycle(alu_op);
    assign w_accept  = in_valid && (r_state == IDLE) && !flush;
    assign w_start   = w_accept && w_multi;
    assign w_sc_fire = w_accept && !w_multi;
    assign w_mc_fire = (r_state == RUN) && w_done && !flush;

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_start),
        .op      (alu_op),
        .a       (a),
        .b       (b),
        .kill    (flush),
        .done    (w_done),
        .res     (w_mc_res)
    );

    // Next-state logic: enter RUN on a multi-cycle accept, leave on done or flush.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_start) w_state_nxt = RUN;
            RUN:  if (flush || w_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output registers: pulse out_valid and capture whichever path completed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_sc_fire || w_mc_fire;
            if (w_sc_fire) begin
                r_result <= w_sc_res;
                r_zero   <= w_sc_zero;
            end else if (w_mc_fire) begin
                r_result <= w_mc_res;
                r_zero   <= 1'b0;
            end
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign busy        = (r_state == RUN);
    assign result      = r_result;
    assign zero        = r_zero;
    assign out_valid   = r_out_valid;
    assign o_dbg_state = r_state;

endmodule
